apb_completer_regbank: RTL and testbench

//  APB completer (slave) at the far end of the APB link. Decodes PSEL/PENABLE/PADDR, serves reads/writes on a

---
 rtl/apb_regbank_pkg.sv | 24 ++
 rtl/apb_regbank_decode.sv | 27 ++
 rtl/apb_completer_regbank.sv | 176 +++++++++++++++++
 tb/tb_apb_completer_regbank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regbank_pkg.sv
// Shared types and constants for the APB completer register bank.
// Optional byte-strobe support in the top is controlled by APB_PSTRB_EN.
package apb_regbank_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam int APB_BYTES  = 4;
  localparam int WAIT_CNT_W = 4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_RO    = 2'd3;

  // First matching cause wins; only "none vs. any" reaches the bus.
  function automatic logic [1:0] decode_err(input logic hit, input logic misaligned,
                                            input logic ro_write);
    if (!hit)            return ERR_RANGE;
    else if (misaligned) return ERR_ALIGN;
    else if (ro_write)   return ERR_RO;
    else                 return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_regbank_decode.sv
// Combinational byte address -> register index decode for the APB register window.
module apb_regbank_decode
  import apb_regbank_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [$clog2(NUM_REGS)-1:0] idx_o,
  output logic                        hit_o,
  output logic                        misaligned_o,
  output logic                        ro_hit_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] offset;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign offset       = addr_i - BASE_ADDR;
  assign hit_o        = offset < ADDR_W'(APB_BYTES * NUM_REGS);
  assign idx_o        = offset[IDX_W+1:2];
  assign misaligned_o = |addr_i[1:0];
  assign ro_hit_o     = hit_o && (idx_o == '0);

endmodule

// File: rtl/apb_completer_regbank.sv
// APB completer serving a bank of 32-bit registers with programmable wait states.
// Define APB_PSTRB_EN to add the PSTRB port and byte-lane write masking.
module apb_completer_regbank
  import apb_regbank_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [APB_BYTES-1:0]       PSTRB,
`endif
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] ctrl_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  err_q, err_d;
  logic                  pwrite_q, pwrite_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [APB_BYTES-1:0]  strb_q, strb_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];

  logic                  setup, accept, commit, dec_err, rd_ok;
  logic [IDX_W-1:0]      dec_idx, rd_idx;
  logic                  dec_hit, dec_mis, dec_ro;
  logic [APB_BYTES-1:0]  strb_in;

`ifdef APB_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0]    old_v,
                                                    input logic [DATA_W-1:0]    new_v,
                                                    input logic [APB_BYTES-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < APB_BYTES; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  apb_regbank_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .BASE_ADDR(BASE_ADDR)
  ) u_decode (
    .addr_i      (PADDR),
    .idx_o       (dec_idx),
    .hit_o       (dec_hit),
    .misaligned_o(dec_mis),
    .ro_hit_o    (dec_ro)
  );

  assign setup   = PSEL && !PENABLE;
  assign dec_err = decode_err(dec_hit, dec_mis, PWRITE && dec_ro) != ERR_NONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_d   = 1'b0;
    err_d      = err_q;
    pwrite_d   = pwrite_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = '0;
    wr_pulse_d = '0;
    accept     = 1'b0;
    commit     = 1'b0;
    rd_idx     = idx_q;
    rd_ok      = 1'b0;

    case (state_q)
      IDLE: accept = setup;
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (pready_q) begin
          commit              = pwrite_q && !err_q;
          wr_pulse_d[idx_q]   = commit;
          state_d             = IDLE;
          accept              = setup;
        end else begin
          pready_d = (cnt_q <= WAIT_CNT_W'(1));
          if (cnt_q != '0) cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The bus is captured once at setup; later changes on PADDR/PWDATA are ignored.
    if (accept) begin
      state_d  = ACCESS;
      cnt_d    = WAIT_CNT_W'(WAIT_CYCLES);
      pready_d = (WAIT_CYCLES == 0);
      err_d    = dec_err;
      pwrite_d = PWRITE;
      idx_d    = dec_idx;
      wdata_d  = PWDATA;
      strb_d   = strb_in;
    end

    // Read data is captured on the edge that raises PREADY, so status_in is
    // sampled in the cycle before PREADY.
    if (pready_d) begin
      rd_idx = accept ? dec_idx : idx_q;
      rd_ok  = accept ? (!PWRITE && !dec_err) : (!pwrite_q && !err_q);
      if (rd_ok) prdata_d = (rd_idx == '0) ? status_in : regs_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      err_q      <= 1'b0;
      pwrite_q   <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      err_q      <= err_d;
      pwrite_q   <= pwrite_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      if (commit) regs_q[idx_q] <= merge_bytes(regs_q[idx_q], wdata_q, strb_q);
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pready_q && err_q;
  assign PRDATA   = prdata_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ctrl
    if (i == 0) begin : g_status
      assign ctrl_out[DATA_W-1:0] = '0;
    end else begin : g_rw
      assign ctrl_out[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_completer_regbank.sv
// Directed bench: one zero-wait and one three-wait completer share the APB bus signals.
module tb_apb_completer_regbank;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel0, psel3, penable, pwrite;
  logic [31:0]  paddr, pwdata, status_in;
`ifdef APB_PSTRB_EN
  logic [3:0]   pstrb;
`endif
  logic [31:0]  prdata0, prdata3;
  logic         ready0, ready3, slverr0, slverr3;
  logic [255:0] ctrl0, ctrl3, exp0;
  logic [7:0]   wp0, wp3;
  logic [7:0]   wp0_last = 8'h00;

  int errors = 0, checks = 0;
  int rdy0_cnt = 0, rdy3_cnt = 0, wp0_cnt = 0, wp3_cnt = 0;
  int b_rdy, b_wp, waits;
  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  apb_completer_regbank #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(ready0), .PSLVERR(slverr0),
    .status_in(status_in), .ctrl_out(ctrl0), .wr_pulse(wp0)
  );

  apb_completer_regbank #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata3), .PREADY(ready3), .PSLVERR(slverr3),
    .status_in(status_in), .ctrl_out(ctrl3), .wr_pulse(wp3)
  );

  always @(negedge clk) begin
    if (ready0) rdy0_cnt++;
    if (ready3) rdy3_cnt++;
    if (|wp0) begin wp0_cnt++; wp0_last = wp0; end
    if (|wp3) wp3_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_img(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setup(input bit s3, input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel0 = !s3; psel3 = s3; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
  endtask

  task automatic access(input bit s3, output int w, output logic [31:0] r, output logic e);
    bit got;
    got = 0; w = 0; r = 'x; e = 'x;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (s3 ? ready3 : ready0) begin
        got = 1;
        r = s3 ? prdata3 : prdata0;
        e = s3 ? slverr3 : slverr0;
      end else begin
        w++;
        @(posedge clk); #1;
      end
    end
    chk("pready_seen", 32'(got), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; status_in = '0;
`ifdef APB_PSTRB_EN
    pstrb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp0 = '0;

    chk("rst_pready0", 32'(ready0), 32'd0);
    chk("rst_pslverr0", 32'(slverr0), 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_wr_pulse0", 32'(wp0), 32'd0);
    chk_img("rst_ctrl0", ctrl0, exp0);
    chk("rst_pready3", 32'(ready3), 32'd0);
    chk_img("rst_ctrl3", ctrl3, '0);

    // zero-wait write then read of reg 1
    b_wp = wp0_cnt;
    setup(0, 1, 32'h04, 32'hDEADBEEF);
    access(0, waits, rd, err);
    chk("wr04_waits", waits, 0);
    chk("wr04_err", 32'(err), 32'd0);
    idle();
    exp0[63:32] = 32'hDEADBEEF;
    chk_img("wr04_ctrl", ctrl0, exp0);
    idle();
    chk("wr04_pulse_cnt", wp0_cnt - b_wp, 1);
    chk("wr04_pulse_idx", 32'(wp0_last), 32'h02);

    setup(0, 0, 32'h04, 32'h0);
    access(0, waits, rd, err);
    chk("rd04_waits", waits, 0);
    chk("rd04_data", rd, 32'hDEADBEEF);
    chk("rd04_err", 32'(err), 32'd0);
    idle(); idle();
    chk("rd04_no_pulse", wp0_cnt - b_wp, 1);

    // three-wait status read
    status_in = 32'h0000A5A5;
    setup(1, 0, 32'h00, 32'h0);
    access(1, waits, rd, err);
    chk("st_waits", waits, 3);
    chk("st_data", rd, 32'h0000A5A5);
    chk("st_err", 32'(err), 32'd0);
    idle();

    // error responses
    b_wp = wp0_cnt;
    setup(0, 1, 32'h00, 32'h12345678);
    access(0, waits, rd, err);
    chk("err_wr00", 32'(err), 32'd1);
    idle();
    setup(0, 1, 32'h20, 32'h87654321);
    access(0, waits, rd, err);
    chk("err_wr20", 32'(err), 32'd1);
    idle();
    setup(0, 0, 32'h06, 32'h0);
    access(0, waits, rd, err);
    chk("err_rd06", 32'(err), 32'd1);
    chk("err_rd06_data", rd, 32'd0);
    idle(); idle();
    chk_img("err_ctrl", ctrl0, exp0);
    chk("err_no_pulse", wp0_cnt - b_wp, 0);

    setup(1, 1, 32'h00, 32'h1);
    access(1, waits, rd, err);
    chk("err3_waits", waits, 3);
    chk("err3_err", 32'(err), 32'd1);
    idle();

`ifdef APB_PSTRB_EN
    pstrb = 4'hF;
    setup(0, 1, 32'h08, 32'h11223344);
    access(0, waits, rd, err);
    idle();
    pstrb = 4'b0101;
    setup(0, 1, 32'h08, 32'hAABBCCDD);
    access(0, waits, rd, err);
    chk("strb_err", 32'(err), 32'd0);
    idle();
    pstrb = 4'hF;
    setup(0, 0, 32'h08, 32'h0);
    access(0, waits, rd, err);
    chk("strb_rd", rd, 32'h11BB33DD);
    idle();
`endif

    // back-to-back writes, no idle gap
    b_rdy = rdy0_cnt; b_wp = wp0_cnt;
    setup(0, 1, 32'h08, 32'h00001111);
    access(0, waits, rd, err);
    setup(0, 1, 32'h0C, 32'h22220000);
    access(0, waits, rd, err);
    idle(); idle();
    exp0[95:64]  = 32'h00001111;
    exp0[127:96] = 32'h22220000;
    chk("b2b_pready_cnt", rdy0_cnt - b_rdy, 2);
    chk("b2b_pulse_cnt", wp0_cnt - b_wp, 2);
    chk("b2b_last_pulse", 32'(wp0_last), 32'h08);
    chk_img("b2b_ctrl", ctrl0, exp0);

    // PSEL dropped during wait states
    b_rdy = rdy3_cnt; b_wp = wp3_cnt;
    setup(1, 1, 32'h10, 32'hCAFEF00D);
    @(posedge clk); #1 penable = 1'b1;
    chk("abort_wait_low", 32'(ready3), 32'd0);
    @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_pready_cnt", rdy3_cnt - b_rdy, 0);
    chk("abort_pulse_cnt", wp3_cnt - b_wp, 0);
    chk_img("abort_ctrl3", ctrl3, '0);

    // reset during a write access, bus left in access phase afterwards
    setup(1, 1, 32'h14, 32'h00000055);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rstacc_pready_cnt", rdy3_cnt - b_rdy, 0);
    chk("rstacc_pulse_cnt", wp3_cnt - b_wp, 0);
    chk("rstacc_pready", 32'(ready3), 32'd0);
    chk("rstacc_pslverr", 32'(slverr3), 32'd0);
    chk("rstacc_prdata", prdata3, 32'd0);
    chk("rstacc_wr_pulse", 32'(wp3), 32'd0);
    chk_img("rstacc_ctrl3", ctrl3, '0);
    chk_img("rstacc_ctrl0", ctrl0, '0);
    psel3 = 1'b0; penable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
